// File: rtl/spi_flash_reader.sv
// SPI NOR flash word reader: wakes the device (0xAB), then serves 0x03 reads returning 32-bit words.
// Latency: data_valid_o pulses 1 + 128*CLK_DIV cycles after the cycle start_i is accepted.
// Backpressure: start_i is only honoured while busy_o=0; requests during busy are dropped, never queued.
module spi_flash_reader #(
    parameter int CLK_DIV          = 2,
    parameter int CS_HIGH_CYCLES   = 4,
    parameter int WAKE_WAIT_CYCLES = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [23:0] addr_i,
    output logic        busy_o,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    output logic        flash_csn,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        flash_wpn,
    output logic        flash_holdn
);

    typedef enum logic [2:0] {
        WAKE_CMD,
        WAKE_WAIT,
        IDLE,
        XFER,
        DESELECT
    } state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] WAKE_LAST = 16'(WAKE_WAIT_CYCLES - 1);
    localparam logic [15:0] CSH_LAST  = 16'(CS_HIGH_CYCLES - 1);

    state_t      state, state_d;
    logic        csn_q, csn_d;
    logic        sclk_q, sclk_d;
    logic [31:0] tx_q, tx_d;      // outgoing bits, MSB drives flash_mosi
    logic [30:0] rx_q, rx_d;      // incoming data bits, first bit deepest
    logic [31:0] rx_next;         // rx history including the bit sampled this cycle
    logic [31:0] data_q, data_d;
    logic [6:0]  bit_q, bit_d;
    logic [7:0]  div_q, div_d;
    logic [15:0] gap_q, gap_d;    // csn-high dwell counter for WAKE_WAIT and DESELECT
    logic        dv_q, dv_d;
    logic [6:0]  last_bit;

    assign rx_next = {rx_q, flash_miso};

    // Next-state and datapath update; one shared bit engine serves both the wake command and reads.
    always_comb begin
        state_d  = state;
        csn_d    = csn_q;
        sclk_d   = sclk_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        data_d   = data_q;
        bit_d    = bit_q;
        div_d    = div_q;
        gap_d    = gap_q;
        dv_d     = 1'b0;
        last_bit = (state == WAKE_CMD) ? 7'd7 : 7'd63;

        case (state)
            WAKE_CMD, XFER: begin
                if (state == WAKE_CMD && csn_q) begin
                    // First cycle out of reset: load the release-power-down opcode and select.
                    tx_d   = {8'hAB, 24'h000000};
                    csn_d  = 1'b0;
                    sclk_d = 1'b0;
                    bit_d  = 7'd0;
                    div_d  = 8'd0;
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Last high-phase cycle: sample miso, present the next mosi bit.
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[30:0], 1'b0};
                        if (bit_q[5]) begin
                            rx_d = rx_next[30:0];
                        end
                        if (bit_q == last_bit) begin
                            csn_d = 1'b1;
                            gap_d = 16'd0;
                            if (state == XFER) begin
                                dv_d    = 1'b1;
                                data_d  = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
                                state_d = DESELECT;
                            end else begin
                                state_d = WAKE_WAIT;
                            end
                        end else begin
                            bit_d = bit_q + 7'd1;
                        end
                    end
                end
            end
            WAKE_WAIT: begin
                if (gap_q == WAKE_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            IDLE: begin
                if (start_i) begin
                    tx_d    = {8'h03, addr_i};
                    rx_d    = 31'd0;
                    csn_d   = 1'b0;
                    sclk_d  = 1'b0;
                    bit_d   = 7'd0;
                    div_d   = 8'd0;
                    state_d = XFER;
                end
            end
            DESELECT: begin
                if (gap_q == CSH_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = WAKE_CMD;
        endcase
    end

    // State register; reset always restarts the wake sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= WAKE_CMD;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and pin registers; reset deselects the flash immediately.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csn_q  <= 1'b1;
            sclk_q <= 1'b0;
            tx_q   <= 32'd0;
            rx_q   <= 31'd0;
            data_q <= 32'd0;
            bit_q  <= 7'd0;
            div_q  <= 8'd0;
            gap_q  <= 16'd0;
            dv_q   <= 1'b0;
        end else begin
            csn_q  <= csn_d;
            sclk_q <= sclk_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            data_q <= data_d;
            bit_q  <= bit_d;
            div_q  <= div_d;
            gap_q  <= gap_d;
            dv_q   <= dv_d;
        end
    end

    assign busy_o       = (state != IDLE);
    assign data_o       = data_q;
    assign data_valid_o = dv_q;
    assign flash_csn    = csn_q;
    assign flash_clk    = sclk_q;
    assign flash_mosi   = tx_q[31];
    assign flash_wpn    = 1'b1;
    assign flash_holdn  = 1'b1;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2 and CLK_DIV=1) share one behavioural flash.
// Latency under test: data_valid_o expected 1 + 128*CLK_DIV cycles after accept.
// Backpressure under test: starts during busy must be dropped.
`timescale 1ns/1ps
module tb_spi_flash_reader;

    localparam int CS_HIGH   = 4;
    localparam int WAKE_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [23:0] addr;
    logic        miso;
    logic        sel;
    logic        busy0, busy1, dv0, dv1;
    logic [31:0] data0, data1;
    logic        csn0, csn1, fclk0, fclk1, mosi0, mosi1, wpn0, wpn1, hold0, hold1;

    always #5 clk = ~clk;

    spi_flash_reader #(.CLK_DIV(2), .CS_HIGH_CYCLES(CS_HIGH), .WAKE_WAIT_CYCLES(WAKE_WAIT)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .addr_i(addr),
        .busy_o(busy0), .data_o(data0), .data_valid_o(dv0),
        .flash_csn(csn0), .flash_clk(fclk0), .flash_mosi(mosi0), .flash_miso(miso),
        .flash_wpn(wpn0), .flash_holdn(hold0));

    spi_flash_reader #(.CLK_DIV(1), .CS_HIGH_CYCLES(CS_HIGH), .WAKE_WAIT_CYCLES(WAKE_WAIT)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .addr_i(addr),
        .busy_o(busy1), .data_o(data1), .data_valid_o(dv1),
        .flash_csn(csn1), .flash_clk(fclk1), .flash_mosi(mosi1), .flash_miso(miso),
        .flash_wpn(wpn1), .flash_holdn(hold1));

    // Signals of whichever instance the flash model is attached to.
    logic        m_csn, m_fclk, m_mosi, m_busy, m_dv;
    logic [31:0] m_data;
    assign m_csn  = sel ? csn1  : csn0;
    assign m_fclk = sel ? fclk1 : fclk0;
    assign m_mosi = sel ? mosi1 : mosi0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_dv   = sel ? dv1   : dv0;
    assign m_data = sel ? data1 : data0;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Flash contents: explicit bytes where loaded, otherwise a pattern derived from the address.
    logic [7:0] mem [logic [23:0]];

    function automatic logic [7:0] fb(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {fb(a + 24'd3), fb(a + 24'd2), fb(a + 24'd1), fb(a)};
    endfunction

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;

    // Flash model / monitor state.
    int          nbits = 0;
    logic [63:0] shreg = 64'd0;
    logic [63:0] last_hdr = 64'd0;
    int          last_nbits = 0;
    logic [23:0] model_addr = 24'd0;
    int          csn_rise_cyc = 0;
    int          last_high_len = 0;
    int          hi_len = 0;
    int          dv_count = 0;
    logic [31:0] last_data = 32'd0;
    logic        prev_csn, prev_fclk, prev_mosi, prev_rst;
    int          k;
    logic [7:0]  mbyte;

    // Sample on the falling edge: behave as the flash, check pin timing, score data_valid_o.
    always @(negedge clk) begin
        if (m_csn === 1'b0 && prev_csn === 1'b1) begin
            nbits = 0;
            shreg = 64'd0;
            last_high_len = cyc - csn_rise_cyc;
        end
        if (m_csn === 1'b1 && prev_csn === 1'b0) begin
            last_hdr   = shreg;
            last_nbits = nbits;
            csn_rise_cyc = cyc;
        end
        if (m_csn === 1'b0 && m_fclk === 1'b1 && prev_fclk === 1'b0) begin
            shreg = {shreg[62:0], m_mosi};
            nbits++;
            if (nbits == 32) model_addr = shreg[23:0];
        end
        if (m_csn === 1'b0 && m_fclk === 1'b0 && prev_fclk === 1'b1 && nbits >= 32 && nbits < 64) begin
            k = nbits - 32;
            mbyte = fb(model_addr + 24'(k / 8));
            miso = mbyte[7 - (k % 8)];
        end
        if (m_fclk === 1'b1) begin
            hi_len++;
        end else if (prev_fclk === 1'b1) begin
            if (prev_rst !== 1'b1) check("clk_high_len", hi_len, sel ? 1 : 2);
            hi_len = 0;
        end
        if (m_csn === 1'b0 && prev_csn === 1'b0 && m_mosi !== prev_mosi)
            check("mosi_change_phase", {prev_fclk, m_fclk}, 2'b10);
        if (m_dv === 1'b1) begin
            dv_count++;
            last_data = m_data;
            check("dv_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                sb_e = sb.pop_front();
                check("sb_data", m_data, sb_e.data);
                check("sb_dv_cycle", cyc, sb_e.due);
                check("sb_mosi_hdr", last_hdr[63:32], {8'h03, sb_e.addr});
                check("sb_mosi_data_zero", last_hdr[31:0], 32'd0);
                check("sb_clk_rises", last_nbits, 64);
                check("sb_csn_high_at_dv", m_csn, 1'b1);
            end
        end
        if (rst === 1'b0 && (sel ? start1 : start0) === 1'b1 && m_busy === 1'b0) begin
            sb_e.addr = addr;
            sb_e.data = exp_word(addr);
            sb_e.due  = cyc + 1 + 128 * (sel ? 1 : 2);
            sb.push_back(sb_e);
        end
        prev_csn  = m_csn;
        prev_fclk = m_fclk;
        prev_mosi = m_mosi;
        prev_rst  = rst;
    end

    task automatic tick_d();
        @(posedge clk);
        #2;
    endtask

    task automatic tick_s();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, output int when);
        int n;
        n = 0;
        tick_s();
        while (m_busy !== 1'b0 && n < budget) begin
            tick_s();
            n++;
        end
        check("wait_idle", m_busy, 1'b0);
        when = cyc;
    endtask

    task automatic wait_sb(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick_s();
            n++;
        end
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic do_start(input logic [23:0] a);
        tick_d();
        addr = a;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        tick_d();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    typedef struct {
        logic        sel;
        logic [23:0] addr;
        logic [31:0] stream;   // bytes in flash order, first byte in [31:24]
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] tmp_stream;
    int          t_idle;
    int          dv_before;
    int          times[$];
    int          n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 24'h000100, 32'h11223344, 32'h44332211};
        vecs[1] = '{1'b0, 24'h123456, 32'h0180FF00, 32'h00FF8001};
        vecs[2] = '{1'b0, 24'hABCDEF, 32'hA55AC33C, 32'h3CC35AA5};
        vecs[3] = '{1'b1, 24'hFFFFFC, 32'hAABBCCDD, 32'hDDCCBBAA};
        vecs[4] = '{1'b1, 24'h000000, 32'hDEADBEEF, 32'hEFBEADDE};
        vecs[5] = '{1'b1, 24'h800001, 32'h12345678, 32'h78563412};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; addr = 24'd0; sel = 1'b0; miso = 1'b0;
        repeat (3) tick_s();
        check("rst_csn",   csn0,  1'b1);
        check("rst_fclk",  fclk0, 1'b0);
        check("rst_mosi",  mosi0, 1'b0);
        check("rst_wpn",   wpn0,  1'b1);
        check("rst_holdn", hold0, 1'b1);
        check("rst_busy",  busy0, 1'b1);
        check("rst_dv",    dv0,   1'b0);
        check("rst_data",  data0, 32'd0);
        check("rst_csn_div1", csn1, 1'b1);

        // Wake sequence after reset release.
        tick_d();
        rst = 1'b0;
        wait_idle(400, t_idle);
        check("wake_nbits", last_nbits, 8);
        check("wake_cmd", last_hdr[7:0], 8'hAB);
        check("wake_csn_high_cycles", t_idle - csn_rise_cyc, WAKE_WAIT);
        check("wake_no_dv", dv_count, 0);

        // Table of reads on both divider settings.
        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].sel;
            tmp_stream = vecs[i].stream;
            for (int j = 0; j < 4; j++)
                mem[vecs[i].addr + 24'(j)] = tmp_stream[31 - 8 * j -: 8];
            wait_idle(400, t_idle);
            do_start(vecs[i].addr);
            wait_sb(600);
            check("vec_data", last_data, vecs[i].exp_data);
        end
        sel = 1'b0;

        // Start during busy is dropped; addr change after accept has no effect.
        wait_idle(400, t_idle);
        dv_before = dv_count;
        tick_d(); addr = 24'h0003F0; start0 = 1'b1;
        tick_d(); start0 = 1'b0;
        tick_d(); addr = 24'h555555;
        tick_d();
        tick_d();
        tick_d(); start0 = 1'b1;
        tick_d(); start0 = 1'b0;
        wait_sb(600);
        repeat (300) tick_s();
        check("busy_start_single_dv", dv_count - dv_before, 1);
        check("busy_start_addr", last_hdr[55:32], 24'h0003F0);

        // Reset in the middle of a read.
        wait_idle(400, t_idle);
        dv_before = dv_count;
        do_start(24'h00ABC0);
        repeat (39) tick_d();
        rst = 1'b1;
        sb.delete();
        tick_s();
        check("abort_pre_csn", csn0, 1'b0);
        tick_d();
        rst = 1'b0;
        tick_s();
        check("abort_csn", csn0, 1'b1);
        check("abort_fclk", fclk0, 1'b0);
        check("abort_busy", busy0, 1'b1);
        wait_idle(400, t_idle);
        check("abort_no_dv", dv_count - dv_before, 0);
        check("abort_rewake_nbits", last_nbits, 8);
        check("abort_rewake_cmd", last_hdr[7:0], 8'hAB);
        check("abort_rewake_gap", t_idle - csn_rise_cyc, WAKE_WAIT);

        // start_i held high: back-to-back reads separated only by DESELECT.
        tick_d();
        addr = 24'h00F000;
        start0 = 1'b1;
        n = 0;
        times.delete();
        while (times.size() < 3 && n < 1200) begin
            tick_s();
            n++;
            if (dv0 === 1'b1) times.push_back(cyc);
        end
        start0 = 1'b0;
        check("b2b_pulse_count", times.size(), 3);
        if (times.size() == 3) begin
            check("b2b_spacing_1", times[1] - times[0], 128 * 2 + CS_HIGH + 1);
            check("b2b_spacing_2", times[2] - times[1], 128 * 2 + CS_HIGH + 1);
            check("b2b_csn_high", last_high_len, CS_HIGH + 1);
        end
        wait_sb(600);
        repeat (300) tick_s();
        check("b2b_no_extra", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
